hb_sample_fifo_periph: RTL and testbench
========================================

// Module: hb_sample_fifo_periph
// PURPOSE
//  AHB-Lite slave that captures samples from NUM_CH heartbeat/sensor producers into per-channel FIFOs.
//  Replaces software-driven ready/ack polling with a hardware 4-phase VLD/ACK handshake.
//  Per-channel controls: enable, flush, overflow mode, IRQ threshold. Sits on the AHB decoder as one HSEL region.
// PARAMETERS
//  NUM_CH     2   producer channels; 1..2^(ADDR_W-5)
//  DATA_W     32  sample width; 1..32, zero-extended on HRDATA
//  FIFO_DEPTH 8   entries per channel; power of 2, >=2
//  ADDR_W     6   HADDR width used for decode
// PORTS
//  HCLK           in   1              bus clock; all logic on rising edge
//  HRESETn        in   1              asynchronous reset, active low
//  HSEL           in   1              slave select
//  HWRITE         in   1              1=write, 0=read
//  HTRANS         in   2              IDLE=00 means no transfer
//  HADDR          in   ADDR_W         byte address, word aligned
//  HWDATA         in   32             write data, valid in data phase
//  HRDATA         out  32             read data, registered
//  IO_SAMPLE      in   NUM_CH*DATA_W  channel c = [c*DATA_W +: DATA_W]; synchronous to HCLK
//  IO_SAMPLE_VLD  in   NUM_CH         producer request, held until ACK
//  IO_SAMPLE_ACK  out  NUM_CH         capture acknowledge
//  IRQ            out  1              OR of per-channel pending flags
// BEHAVIOUR
//  Reset: all outputs 0, FIFOs empty, CTRL=0 (channels disabled), OVF_CNT=0.
//  Decode
//   HADDR[ADDR_W-1]=0: channel ch=HADDR[ADDR_W-2:4], reg=HADDR[3:2]. Otherwise global.
//   Channel regs: 0 DATA(RO), 1 STATUS(RO), 2 CTRL(RW), 3 OVF_CNT(write-any clears).
//   Global reg 0: IRQ_PEND[NUM_CH-1:0] (RO). Unmapped: reads 0, writes ignored.
//  Reads
//   Address phase with HSEL & HTRANS!=IDLE & !HWRITE registers HRDATA at that edge; data valid in the data phase.
//   Reading DATA pops at the same edge. An empty FIFO returns 0 and does not pop.
//   HRDATA holds its value when the slave is not selected.
//  Writes
//   HADDR/HWRITE/HSEL/HTRANS are registered one cycle; HWDATA is applied at the data-phase edge.
//  CTRL fields
//   [0] EN; [1] DROP (1=drop on full, 0=backpressure); [2] IRQ_EN; [3] FLUSH (self-clearing, reads 0).
//   [15:8] THRESH; the effective threshold clamps to FIFO_DEPTH.
//  STATUS fields
//   [0] empty; [1] full; [2] ovf_sticky (cleared by OVF_CNT write); [15:8] count (0..FIFO_DEPTH).
//  Handshake, per channel, 4-phase
//   Push at edge k if EN & VLD & !ACK & !full. Sample written, ACK=1 after edge k, count visible at k+1.
//   ACK stays 1 until VLD sampled 0, then ACK=0 at the next edge.
//   Full & !DROP: no push, ACK held 0 (backpressure), no data loss.
//   Full & DROP: ACK=1, sample discarded, OVF_CNT +1 (16-bit, saturates at 0xFFFF), ovf_sticky=1.
//  Full check uses the pre-edge count: a pop in the same cycle does not admit a push.
//  Simultaneous push+pop on a non-full, non-empty FIFO: both occur, count unchanged.
//  Pointers wrap modulo FIFO_DEPTH; count is tracked separately (width clog2(FIFO_DEPTH)+1).
//  EN cleared mid-handshake: a pending ACK still completes; no new pushes.
//  FLUSH empties the FIFO in one cycle and has priority over push/pop in that cycle.
//  IRQ_PEND[c] = IRQ_EN & (count >= THRESH | ovf_sticky); IRQ = |IRQ_PEND; combinational from registers.
//  Reset mid-transfer: FIFOs emptied, ACK dropped immediately (async); producers must re-issue VLD.
// STRUCTURE
//  Package hb_periph_pkg: reg offset enum {DATA, STATUS, CTRL, OVF_CNT}, ctrl_t packed struct,
//   STATUS bit positions, HTRANS_IDLE.
//  Sub-module hb_sample_fifo (DATA_W, FIFO_DEPTH): sync FIFO with push/pop/flush, count, full/empty;
//   one instance per channel via generate.
// TESTING
//  1. Reset, ch0 EN=1, VLD with 0xA5: ACK=1 next cycle; STATUS count=1; DATA read=0xA5, then STATUS empty=1.
//  2. DEPTH=8, !DROP: push 9 samples 1..9. 9th: ACK stays 0 until one DATA read, then captured.
//     Reads return 1..9 in order.
//  3. DROP=1, fill 8, push 3 more: ACK pulses each time, OVF_CNT=3, ovf_sticky=1. OVF_CNT write clears both.
//  4. THRESH=4, IRQ_EN=1: IRQ rises when count 3->4; falls when a read brings count to 3.
//  5. Same-cycle push ch0 and DATA read ch0 at count=5: count stays 5. ch1 unaffected.
//  6. HRESETn low while ch1 ACK=1 and count=6: ACK=0 async, count=0, CTRL=0, HRDATA=0.

Source files
------------

// File: rtl/hb_periph_pkg.sv
// Shared definitions for the heartbeat sample FIFO peripheral.
//   reg_off_e   : per-channel register offsets (HADDR[3:2])
//   ctrl_t      : CTRL register layout (16 bits, zero-extended on the bus)
//   ST_*        : STATUS register bit positions
//   HTRANS_IDLE : AHB "no transfer" encoding
package hb_periph_pkg;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CTRL    = 2'd2,
        REG_OVF_CNT = 2'd3
    } reg_off_e;

    typedef struct packed {
        logic [7:0] thresh;   // [15:8] IRQ level, clamped to FIFO_DEPTH when used
        logic [3:0] rsvd;     // [7:4]
        logic       flush;    // [3] write-1 pulse, never stored
        logic       irq_en;   // [2]
        logic       drop;     // [1] 1: discard on full, 0: backpressure
        logic       en;       // [0]
    } ctrl_t;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

endpackage

// File: rtl/hb_sample_fifo.sv
// Synchronous FIFO holding samples for one producer channel.
//   HCLK, HRESETn : clock, async active-low reset (pointers/count cleared)
//   push, pop     : requests; ignored when full / empty respectively
//   flush         : empties the FIFO, wins over push and pop that cycle
//   wdata, rdata  : write data; rdata shows the head entry (valid when !empty)
//   count         : occupancy 0..FIFO_DEPTH
//   full, empty   : decoded from count
module hb_sample_fifo #(
    parameter int  DATA_W     = 32,
    parameter int  FIFO_DEPTH = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hb_sample_fifo_periph.sv
// AHB-Lite slave capturing samples from NUM_CH producers into per-channel FIFOs.
//   HCLK, HRESETn                 : bus clock, async active-low reset
//   HSEL, HWRITE, HTRANS, HADDR   : AHB address phase
//   HWDATA                        : write data (data phase)
//   HRDATA                        : registered read data
//   IO_SAMPLE, IO_SAMPLE_VLD      : producer data / request per channel
//   IO_SAMPLE_ACK                 : capture acknowledge per channel
//   IRQ                           : OR of per-channel pending flags
// Address map: HADDR[ADDR_W-1]=0 selects channel HADDR[ADDR_W-2:4], register
// HADDR[3:2] (DATA, STATUS, CTRL, OVF_CNT). Otherwise global; offset 0 is IRQ_PEND.
module hb_sample_fifo_periph
    import hb_periph_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 6
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic                     HWRITE,
    input  logic [1:0]               HTRANS,
    input  logic [ADDR_W-1:0]        HADDR,
    input  logic [31:0]              HWDATA,
    output logic [31:0]              HRDATA,
    input  logic [NUM_CH*DATA_W-1:0] IO_SAMPLE,
    input  logic [NUM_CH-1:0]        IO_SAMPLE_VLD,
    output logic [NUM_CH-1:0]        IO_SAMPLE_ACK,
    output logic                     IRQ
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CH_W  = ADDR_W - 5;

    logic [DATA_W-1:0] f_rdata [NUM_CH];
    logic [CNT_W-1:0]  f_count [NUM_CH];
    ctrl_t             ctrl_q  [NUM_CH];
    logic [15:0]       ovf_q   [NUM_CH];
    logic [NUM_CH-1:0] f_full;
    logic [NUM_CH-1:0] f_empty;
    logic [NUM_CH-1:0] sticky_q;
    logic [NUM_CH-1:0] irq_pend;
    logic [NUM_CH-1:0] pop_vec;

    // ---------------- read path (acts in the address phase) ----------------
    logic              rd_req;
    logic [CH_W-1:0]   a_ch;
    logic [31:0]       rd_data;

    assign rd_req = HSEL && (HTRANS != HTRANS_IDLE) && !HWRITE;
    assign a_ch   = HADDR[ADDR_W-2:4];

    always_comb begin
        rd_data = '0;
        pop_vec = '0;
        if (!HADDR[ADDR_W-1]) begin
            if (int'(a_ch) < NUM_CH) begin
                case (reg_off_e'(HADDR[3:2]))
                    REG_DATA: begin
                        // An empty FIFO reads 0 and is left untouched.
                        if (!f_empty[a_ch]) begin
                            rd_data       = 32'(f_rdata[a_ch]);
                            pop_vec[a_ch] = rd_req;
                        end
                    end
                    REG_STATUS: begin
                        rd_data[ST_EMPTY]          = f_empty[a_ch];
                        rd_data[ST_FULL]           = f_full[a_ch];
                        rd_data[ST_OVF]            = sticky_q[a_ch];
                        rd_data[ST_CNT_LSB +: 8]   = 8'(f_count[a_ch]);
                    end
                    REG_CTRL:    rd_data = {16'h0, ctrl_q[a_ch]};
                    REG_OVF_CNT: rd_data = {16'h0, ovf_q[a_ch]};
                endcase
            end
        end else if (HADDR[ADDR_W-2:2] == '0) begin
            rd_data = 32'(irq_pend);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)    HRDATA <= '0;
        else if (rd_req) HRDATA <= rd_data;
    end

    // ---------------- write path (address registered, data next edge) ------
    logic              wr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [CH_W-1:0]   w_ch;
    logic              w_hit_ch;
    reg_off_e          w_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_q <= HSEL && (HTRANS != HTRANS_IDLE) && HWRITE;
            if (HSEL && (HTRANS != HTRANS_IDLE) && HWRITE) wr_addr_q <= HADDR;
        end
    end

    assign w_ch     = wr_addr_q[ADDR_W-2:4];
    assign w_reg    = reg_off_e'(wr_addr_q[3:2]);
    assign w_hit_ch = wr_q && !wr_addr_q[ADDR_W-1] && (int'(w_ch) < NUM_CH);

    // ---------------- per-channel capture ----------------
    // Producer handshake (4-phase): the producer raises VLD with stable data and
    // holds both until ACK=1; ACK then stays 1 until VLD is seen low, and falls on
    // the following edge. A new request is only taken while ACK=0. When the FIFO is
    // full and DROP=0 the request simply waits (ACK held 0); with DROP=1 it is
    // acknowledged and the sample is counted as an overflow.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ctrl_t       ctrl_r;
        logic        ack_r;
        logic [15:0] ovf_r;
        logic        sticky_r;
        logic        sel;
        logic        wr_ctrl;
        logic        wr_ovf;
        logic        flush;
        logic        vld;
        logic        accept;
        logic        push;
        logic        drop_hit;
        int          thr_eff;

        assign sel      = w_hit_ch && (int'(w_ch) == c);
        assign wr_ctrl  = sel && (w_reg == REG_CTRL);
        assign wr_ovf   = sel && (w_reg == REG_OVF_CNT);
        assign flush    = wr_ctrl && HWDATA[3];
        assign vld      = IO_SAMPLE_VLD[c];
        // A flush cycle takes no request, so the producer retries into the
        // emptied FIFO instead of losing the sample.
        assign accept   = ctrl_r.en && vld && !ack_r && !flush;
        assign push     = accept && !f_full[c];
        assign drop_hit = accept && f_full[c] && ctrl_r.drop;

        hb_sample_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .push    (push),
            .pop     (pop_vec[c]),
            .flush   (flush),
            .wdata   (IO_SAMPLE[c*DATA_W +: DATA_W]),
            .rdata   (f_rdata[c]),
            .count   (f_count[c]),
            .full    (f_full[c]),
            .empty   (f_empty[c])
        );

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                ctrl_r   <= '0;
                ack_r    <= 1'b0;
                ovf_r    <= '0;
                sticky_r <= 1'b0;
            end else begin
                if (wr_ctrl) begin
                    ctrl_r        <= '0;
                    ctrl_r.thresh <= HWDATA[15:8];
                    ctrl_r.irq_en <= HWDATA[2];
                    ctrl_r.drop   <= HWDATA[1];
                    ctrl_r.en     <= HWDATA[0];
                end
                // Release does not depend on EN, so a handshake in flight completes.
                if (push || drop_hit)  ack_r <= 1'b1;
                else if (ack_r && !vld) ack_r <= 1'b0;
                // A clearing write wins over an overflow in the same cycle.
                if (wr_ovf) begin
                    ovf_r    <= '0;
                    sticky_r <= 1'b0;
                end else if (drop_hit) begin
                    if (ovf_r != 16'hFFFF) ovf_r <= ovf_r + 16'd1;
                    sticky_r <= 1'b1;
                end
            end
        end

        assign thr_eff          = (int'(ctrl_r.thresh) > FIFO_DEPTH) ? FIFO_DEPTH
                                                                     : int'(ctrl_r.thresh);
        assign irq_pend[c]      = ctrl_r.irq_en && ((int'(f_count[c]) >= thr_eff) || sticky_r);
        assign ctrl_q[c]        = ctrl_r;
        assign ovf_q[c]         = ovf_r;
        assign sticky_q[c]      = sticky_r;
        assign IO_SAMPLE_ACK[c] = ack_r;
    end

    assign IRQ = |irq_pend;

    logic unused_bits;
    assign unused_bits = ^{HADDR[1:0], wr_addr_q[1:0], HWDATA[31:16], HWDATA[7:4]};

endmodule

// File: tb/tb_hb_sample_fifo_periph.sv
module tb_hb_sample_fifo_periph;

  localparam int NUM_CH     = 2;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 6;

  // register addresses
  localparam logic [ADDR_W-1:0] A0_DATA = 6'h00, A0_STAT = 6'h04, A0_CTRL = 6'h08, A0_OVF = 6'h0C;
  localparam logic [ADDR_W-1:0] A1_DATA = 6'h10, A1_STAT = 6'h14, A1_CTRL = 6'h18;
  localparam logic [ADDR_W-1:0] A_IRQ = 6'h20, A_UNMAP = 6'h24;

  logic                     HCLK;
  logic                     HRESETn;
  logic                     HSEL;
  logic                     HWRITE;
  logic [1:0]               HTRANS;
  logic [ADDR_W-1:0]        HADDR;
  logic [31:0]              HWDATA;
  logic [31:0]              HRDATA;
  logic [NUM_CH*DATA_W-1:0] IO_SAMPLE;
  logic [NUM_CH-1:0]        IO_SAMPLE_VLD;
  logic [NUM_CH-1:0]        IO_SAMPLE_ACK;
  logic                     IRQ;

  int total = 0;
  int bad   = 0;

  // scoreboard: samples the DUT has acknowledged and must hand back in order
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit          sticky_m0;

  hb_sample_fifo_periph #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .IO_SAMPLE(IO_SAMPLE),
    .IO_SAMPLE_VLD(IO_SAMPLE_VLD), .IO_SAMPLE_ACK(IO_SAMPLE_ACK), .IRQ(IRQ)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp(input int n, input bit stk);
    logic [31:0] s;
    s       = '0;
    s[0]    = (n == 0);
    s[1]    = (n == FIFO_DEPTH);
    s[2]    = stk;
    s[15:8] = 8'(n);
    return s;
  endfunction

  // ---------------- drivers ----------------
  task automatic ahb_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  task automatic ahb_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(addr, d);
    check(tag, d, exp);
  endtask

  // DATA read against the scoreboard; an empty queue means 0 is expected
  task automatic read_data(input int ch);
    logic [31:0] d;
    logic [31:0] e;
    ahb_read(ch == 0 ? A0_DATA : A1_DATA, d);
    e = 32'h0;
    if (ch == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
    if (ch == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    check(ch == 0 ? "data0" : "data1", d, e);
  endtask

  // full 4-phase producer transaction; lat = edges until ACK seen
  task automatic push_sample(input int ch, input logic [31:0] val, input bit store, output int lat);
    lat = 0;
    IO_SAMPLE[ch*DATA_W +: DATA_W] = val;
    IO_SAMPLE_VLD[ch] = 1'b1;
    while (IO_SAMPLE_ACK[ch] !== 1'b1 && lat < 60) begin
      @(posedge HCLK); #1;
      lat++;
    end
    if (IO_SAMPLE_ACK[ch] !== 1'b1) begin
      check("ack_timeout", {31'h0, IO_SAMPLE_ACK[ch]}, 32'h1);
      IO_SAMPLE_VLD[ch] = 1'b0;
      return;
    end
    if (store) begin
      if (ch == 0) exp_q0.push_back(val);
      else         exp_q1.push_back(val);
    end
    IO_SAMPLE_VLD[ch] = 1'b0;
    @(posedge HCLK); #1;
    check("ack_release", {31'h0, IO_SAMPLE_ACK[ch]}, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int lat9;
    HRESETn = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HADDR = '0; HWDATA = '0;
    IO_SAMPLE = '0; IO_SAMPLE_VLD = '0;
    sticky_m0 = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_ack", {30'h0, IO_SAMPLE_ACK}, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    read_check("rst_stat0", A0_STAT, status_exp(0, 0));
    read_check("rst_ctrl0", A0_CTRL, 32'h0);
    read_check("rst_ovf0", A0_OVF, 32'h0);
    read_check("unmapped", A_UNMAP, 32'h0);

    // 1: single capture
    ahb_write(A0_CTRL, 32'h1);
    push_sample(0, 32'hA5, 1, lat);
    check("t1_ack_lat", lat, 1);
    read_check("t1_stat", A0_STAT, status_exp(exp_q0.size(), 0));
    read_data(0);
    read_check("t1_stat_empty", A0_STAT, status_exp(0, 0));
    read_data(0);  // empty FIFO reads 0

    // 2: backpressure at full
    for (int i = 1; i <= 8; i++) push_sample(0, i, 1, lat);
    read_check("t2_full", A0_STAT, status_exp(8, 0));
    fork
      push_sample(0, 9, 1, lat9);
      begin
        repeat (5) @(posedge HCLK);
        #1;
        check("t2_ack_held", {31'h0, IO_SAMPLE_ACK[0]}, 32'h0);
        read_data(0);
      end
    join
    check("t2_stall", {31'h0, 1'(lat9 > 5)}, 32'h1);
    for (int i = 0; i < 8; i++) read_data(0);
    read_check("t2_empty", A0_STAT, status_exp(0, 0));

    // 3: drop on full
    ahb_write(A0_CTRL, 32'h3);
    for (int i = 0; i < 8; i++) push_sample(0, 32'h100 + i, 1, lat);
    for (int i = 0; i < 3; i++) begin
      push_sample(0, 32'h200 + i, 0, lat);
      check("t3_drop_ack", lat, 1);
    end
    sticky_m0 = 1'b1;
    read_check("t3_ovf", A0_OVF, 32'd3);
    read_check("t3_stat", A0_STAT, status_exp(exp_q0.size(), sticky_m0));
    ahb_write(A0_OVF, 32'h1234);
    sticky_m0 = 1'b0;
    read_check("t3_ovf_clr", A0_OVF, 32'd0);
    read_check("t3_stat_clr", A0_STAT, status_exp(exp_q0.size(), sticky_m0));
    for (int i = 0; i < 8; i++) read_data(0);

    // 4: threshold IRQ
    ahb_write(A0_CTRL, 32'h0405);
    for (int i = 0; i < 3; i++) push_sample(0, 32'h300 + i, 1, lat);
    check("t4_irq_lo", {31'h0, IRQ}, 32'h0);
    push_sample(0, 32'h303, 1, lat);
    check("t4_irq_hi", {31'h0, IRQ}, 32'h1);
    read_check("t4_pend", A_IRQ, 32'h1);
    read_data(0);
    check("t4_irq_fall", {31'h0, IRQ}, 32'h0);
    for (int i = 0; i < 3; i++) read_data(0);

    // 5: same-cycle push and pop
    ahb_write(A0_CTRL, 32'h1);
    ahb_write(A1_CTRL, 32'h1);
    push_sample(1, 32'hB0, 1, lat);
    push_sample(1, 32'hB1, 1, lat);
    for (int i = 0; i < 5; i++) push_sample(0, 32'h400 + i, 1, lat);
    fork
      push_sample(0, 32'h405, 1, lat);
      read_data(0);
    join
    check("t5_same_edge", lat, 1);
    read_check("t5_cnt0", A0_STAT, status_exp(5, 0));
    read_check("t5_cnt1", A1_STAT, status_exp(exp_q1.size(), 0));

    // flush
    ahb_write(A0_CTRL, 32'h9);
    exp_q0.delete();
    read_check("flush_stat", A0_STAT, status_exp(0, 0));
    read_check("flush_ctrl", A0_CTRL, 32'h1);

    // 6: reset in the middle of a handshake
    for (int i = 0; i < 3; i++) push_sample(1, 32'hB2 + i, 1, lat);
    IO_SAMPLE[DATA_W +: DATA_W] = 32'hB5;
    IO_SAMPLE_VLD[1] = 1'b1;
    @(posedge HCLK); #1;
    check("t6_ack_hi", {31'h0, IO_SAMPLE_ACK[1]}, 32'h1);
    exp_q1.push_back(32'hB5);
    read_check("t6_cnt6", A1_STAT, status_exp(exp_q1.size(), 0));
    #2;
    HRESETn = 1'b0;
    #1;
    check("t6_ack_async", {31'h0, IO_SAMPLE_ACK[1]}, 32'h0);
    check("t6_hrdata", HRDATA, 32'h0);
    IO_SAMPLE_VLD = '0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    read_check("t6_stat1", A1_STAT, status_exp(0, 0));
    read_check("t6_ctrl1", A1_CTRL, 32'h0);
    read_data(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
